// File: rtl/pipe_stage_reg_if.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg_if
// Bundle between an upstream pipeline stage, one inter-stage register and the
// hazard unit.
//   stall, flush          stage control from the hazard unit
//   in_*                  upstream slot contents (valid, pc, instr, result,
//                         store data, destination register, Tnew)
//   out_*                 registered copies presented to the next stage
//   fw_addr/value/ready   this stage's forwarding tap
// Modports:
//   master  upstream / hazard-unit side (drives in_* and controls)
//   slave   the stage register itself (drives out_* and fw_*)
// ----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int TNEW_W = 2
);
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_instr;
    logic [DATA_W-1:0] in_result;
    logic [DATA_W-1:0] in_st_data;
    logic [REG_AW-1:0] in_wa;
    logic [TNEW_W-1:0] in_tnew;

    logic              out_valid;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_instr;
    logic [DATA_W-1:0] out_result;
    logic [DATA_W-1:0] out_st_data;
    logic [REG_AW-1:0] out_wa;
    logic [TNEW_W-1:0] out_tnew;

    logic [REG_AW-1:0] fw_addr;
    logic [DATA_W-1:0] fw_value;
    logic              fw_ready;

    modport master (
        output stall, flush, in_valid, in_pc, in_instr, in_result,
               in_st_data, in_wa, in_tnew,
        input  out_valid, out_pc, out_instr, out_result, out_st_data,
               out_wa, out_tnew, fw_addr, fw_value, fw_ready
    );

    modport slave (
        input  stall, flush, in_valid, in_pc, in_instr, in_result,
               in_st_data, in_wa, in_tnew,
        output out_valid, out_pc, out_instr, out_result, out_st_data,
               out_wa, out_tnew, fw_addr, fw_value, fw_ready
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
// Inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) for the 5-stage MIPS
// core. Carries PC, instruction, result, store data, destination register and
// Tnew; supports stall (hold), flush (bubble) and a valid bit, decrements Tnew
// once per stage and drives the stage's forwarding tap.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    pipe_stage_reg_if.slave (controls, in_*, out_*, fw_*)
// Optional feature macro: PIPE_STAGE_STATS_EN
//   adds stall_cycles / bubble_cycles saturating 32-bit counters.
// Edge priority: reset > flush > stall > load.
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                DATA_W   = 32,
    parameter int                REG_AW   = 5,
    parameter int                TNEW_W   = 2,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(32'h0000_3000)
) (
    input  logic              clk,
    input  logic              reset,
    pipe_stage_reg_if.slave   bus
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles
`endif
);

    logic              r_valid;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_st_data;
    logic [REG_AW-1:0] r_wa;
    logic [TNEW_W-1:0] r_tnew;

    // Tnew saturates at zero: a result already available stays available.
    logic [TNEW_W-1:0] w_tnew_dec;
    assign w_tnew_dec = (bus.in_tnew == '0) ? '0 : bus.in_tnew - TNEW_W'(1);

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_valid   <= 1'b0;
            r_pc      <= RESET_PC;
            r_instr   <= '0;
            r_result  <= '0;
            r_st_data <= '0;
            r_wa      <= '0;
            r_tnew    <= '0;
        end else if (!bus.stall) begin
            r_valid   <= bus.in_valid;
            r_pc      <= bus.in_pc;
            r_instr   <= bus.in_instr;
            r_result  <= bus.in_result;
            r_st_data <= bus.in_st_data;
            // An empty slot must never advertise a producer.
            r_wa      <= bus.in_valid ? bus.in_wa : '0;
            r_tnew    <= bus.in_valid ? w_tnew_dec : '0;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_bubble_cycles;
    logic        w_bubble_load;

    assign w_bubble_load = bus.flush || (!bus.stall && !bus.in_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles  <= '0;
            r_bubble_cycles <= '0;
        end else begin
            if (bus.stall && !bus.flush && r_stall_cycles != 32'hFFFF_FFFF)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_bubble_load && r_bubble_cycles != 32'hFFFF_FFFF)
                r_bubble_cycles <= r_bubble_cycles + 32'd1;
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign bubble_cycles = r_bubble_cycles;
`endif

    assign bus.out_valid   = r_valid;
    assign bus.out_pc      = r_pc;
    assign bus.out_instr   = r_instr;
    assign bus.out_result  = r_result;
    assign bus.out_st_data = r_st_data;
    assign bus.out_wa      = r_wa;
    assign bus.out_tnew    = r_tnew;

    // $0 is never forwarded; fw_addr == 0 means "no producer here".
    assign bus.fw_addr  = r_valid ? r_wa : '0;
    assign bus.fw_value = r_result;
    assign bus.fw_ready = r_valid && (r_wa != '0) && (r_tnew == '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg: reset, load, Tnew decrement/saturation,
// stall hold, flush-over-stall, invalid loads, $0 destination and reset during
// stall. Counter checks are present when PIPE_STAGE_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    pipe_stage_reg_if #(.DATA_W(32), .REG_AW(5), .TNEW_W(2)) u_if ();

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] bubble_cycles;
`endif

    pipe_stage_reg #(
        .DATA_W  (32),
        .REG_AW  (5),
        .TNEW_W  (2),
        .RESET_PC(32'h0000_3000)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (u_if)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .bubble_cycles(bubble_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] wa, input logic [1:0] tnew);
        u_if.in_valid   = v;
        u_if.in_pc      = pc;
        u_if.in_instr   = instr;
        u_if.in_result  = res;
        u_if.in_st_data = sd;
        u_if.in_wa      = wa;
        u_if.in_tnew    = tnew;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        u_if.stall = 1'b0;
        u_if.flush = 1'b0;
        drive(1'b1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 5'd7, 2'd3);
        @(negedge clk);

        // 1: reset
        tick();
        reset = 1'b0;
        chk("rst_pc",     u_if.out_pc,      32'h0000_3000);
        chk("rst_valid",  u_if.out_valid,   0);
        chk("rst_instr",  u_if.out_instr,   0);
        chk("rst_tnew",   u_if.out_tnew,    0);
        chk("rst_fwaddr", u_if.fw_addr,     0);
        chk("rst_fwrdy",  u_if.fw_ready,    0);
`ifdef PIPE_STAGE_STATS_EN
        chk("rst_stallc", stall_cycles,  0);
        chk("rst_bublc",  bubble_cycles, 0);
`endif

        // 2: addu $3 with tnew=1
        drive(1'b1, 32'h0000_3004, 32'h0022_1821, 32'd5, 32'h0000_00AA, 5'd3, 2'd1);
        tick();
        chk("t2_valid",  u_if.out_valid,   1);
        chk("t2_pc",     u_if.out_pc,      32'h0000_3004);
        chk("t2_instr",  u_if.out_instr,   32'h0022_1821);
        chk("t2_sd",     u_if.out_st_data, 32'h0000_00AA);
        chk("t2_tnew",   u_if.out_tnew,    0);
        chk("t2_fwaddr", u_if.fw_addr,     3);
        chk("t2_fwval",  u_if.fw_value,    5);
        chk("t2_fwrdy",  u_if.fw_ready,    1);

        // 3: lw $8 with tnew=2, then stall 3 cycles with junk on inputs
        drive(1'b1, 32'h0000_3008, 32'h8C08_0000, 32'h0000_0100, 32'h0, 5'd8, 2'd2);
        tick();
        chk("t3_tnew",   u_if.out_tnew, 1);
        chk("t3_fwaddr", u_if.fw_addr,  8);
        chk("t3_fwrdy",  u_if.fw_ready, 0);
        u_if.stall = 1'b1;
        drive(1'b1, 32'h0000_DEAD, 32'hFFFF_FFFF, 32'h9, 32'h9, 5'd9, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_tnew", u_if.out_tnew,   1);
            chk("t3_hold_pc",   u_if.out_pc,     32'h0000_3008);
            chk("t3_hold_res",  u_if.out_result, 32'h0000_0100);
            chk("t3_hold_rdy",  u_if.fw_ready,   0);
        end
`ifdef PIPE_STAGE_STATS_EN
        chk("t3_stallc", stall_cycles,  3);
        chk("t3_bublc",  bubble_cycles, 0);
`endif

        // 4: stall and flush together -> bubble
        u_if.flush = 1'b1;
        tick();
        u_if.flush = 1'b0;
        u_if.stall = 1'b0;
        chk("t4_valid",  u_if.out_valid, 0);
        chk("t4_instr",  u_if.out_instr, 0);
        chk("t4_pc",     u_if.out_pc,    32'h0000_3000);
        chk("t4_wa",     u_if.out_wa,    0);
        chk("t4_fwaddr", u_if.fw_addr,   0);
`ifdef PIPE_STAGE_STATS_EN
        chk("t4_stallc", stall_cycles,  3);
        chk("t4_bublc",  bubble_cycles, 1);
`endif

        // 5: valid with wa=0 never forwards
        drive(1'b1, 32'h0000_300C, 32'h0000_0000, 32'd7, 32'h0, 5'd0, 2'd0);
        tick();
        chk("t5_valid",  u_if.out_valid, 1);
        chk("t5_fwaddr", u_if.fw_addr,   0);
        chk("t5_fwrdy",  u_if.fw_ready,  0);

        // 6: tnew=0 saturates, tnew=3 decrements
        drive(1'b1, 32'h0000_3010, 32'h0001_2021, 32'd9, 32'h0, 5'd4, 2'd0);
        tick();
        chk("t6_tnew0",  u_if.out_tnew, 0);
        chk("t6_fwrdy",  u_if.fw_ready, 1);
        drive(1'b1, 32'h0000_3014, 32'h0001_2021, 32'd9, 32'h0, 5'd4, 2'd3);
        tick();
        chk("t6_tnew3",  u_if.out_tnew, 2);
        chk("t6_rdy3",   u_if.fw_ready, 0);

        // invalid load: fields copied, wa/tnew cleared
        drive(1'b0, 32'h0000_4000, 32'h1234_5678, 32'h77, 32'h55, 5'd5, 2'd3);
        tick();
        chk("inv_valid", u_if.out_valid,  0);
        chk("inv_pc",    u_if.out_pc,     32'h0000_4000);
        chk("inv_instr", u_if.out_instr,  32'h1234_5678);
        chk("inv_res",   u_if.out_result, 32'h77);
        chk("inv_wa",    u_if.out_wa,     0);
        chk("inv_tnew",  u_if.out_tnew,   0);
        chk("inv_fwadr", u_if.fw_addr,    0);
`ifdef PIPE_STAGE_STATS_EN
        chk("inv_bublc", bubble_cycles, 2);
`endif

        // plain flush without stall
        drive(1'b1, 32'h0000_4004, 32'hABCD_0001, 32'h11, 32'h22, 5'd10, 2'd1);
        tick();
        chk("pre_fl_wa", u_if.out_wa, 10);
        u_if.flush = 1'b1;
        tick();
        u_if.flush = 1'b0;
        chk("fl_res",    u_if.out_result,  0);
        chk("fl_sd",     u_if.out_st_data, 0);
        chk("fl_valid",  u_if.out_valid,   0);

        // reset during stall
        drive(1'b1, 32'h0000_5000, 32'h0000_1111, 32'h66, 32'h44, 5'd6, 2'd2);
        tick();
        chk("pre_rs_wa", u_if.out_wa, 6);
        u_if.stall = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        u_if.stall = 1'b0;
        chk("rs_pc",     u_if.out_pc,      32'h0000_3000);
        chk("rs_valid",  u_if.out_valid,   0);
        chk("rs_instr",  u_if.out_instr,   0);
        chk("rs_res",    u_if.out_result,  0);
        chk("rs_sd",     u_if.out_st_data, 0);
        chk("rs_wa",     u_if.out_wa,      0);
        chk("rs_tnew",   u_if.out_tnew,    0);
        chk("rs_fwrdy",  u_if.fw_ready,    0);
`ifdef PIPE_STAGE_STATS_EN
        chk("rs_stallc", stall_cycles,  0);
        chk("rs_bublc",  bubble_cycles, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
